// File: rtl/n_shift_tx_if.sv
// Load handshake and serial-side signals of the n_shift_tx transmitter.
interface n_shift_tx_if #(
   parameter int N = 7
) ();
   logic         load_valid;
   logic         load_ready;
   logic [N-1:0] din;
   logic         sr_out;
   logic         sr_en;
   logic         busy;
   logic         done;

   modport master (
      output load_valid, din,
      input  load_ready, sr_out, sr_en, busy, done
   );

   modport slave (
      input  load_valid, din,
      output load_ready, sr_out, sr_en, busy, done
   );
endinterface

// File: rtl/n_shift_tx.sv
// Parallel-in, serial-out transmitter: sends an N-bit word LSB first, one
// sr_en strobe per bit, with an optional DIV-cycle bit period.
module n_shift_tx #(
   parameter int N   = 7,
   parameter int DIV = 1
) (
   input  logic        clk,
   input  logic        rst,
   n_shift_tx_if.slave bus
);

   localparam int BW = $clog2(N);
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [N-1:0]    r_sh;
   logic [BW-1:0]   r_bit;
   logic [DW-1:0]   r_div;
   logic            w_accept;
   logic            w_strobe;
   logic            w_last;

   // NOTE: reset is sampled on the clock edge only, so it sits inside the
   // clocked branch rather than in the sensitivity list.
   always_ff @(posedge clk) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_strobe = 1'b0;
      w_last   = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.load_valid) begin
               w_accept = 1'b1;
               w_next   = SHIFT;
            end
         end
         SHIFT: begin
            w_strobe = (r_div == DIV_LAST);
            w_last   = w_strobe && (r_bit == BIT_LAST);
            if (w_last) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Zero-fill on shift leaves sh empty after the last bit, so sr_out idles at 0.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_sh  <= '0;
         r_bit <= '0;
         r_div <= '0;
      end else if (w_accept) begin
         r_sh  <= bus.din;
         r_bit <= '0;
         r_div <= '0;
      end else if (w_strobe) begin
         r_sh  <= {1'b0, r_sh[N-1:1]};
         r_div <= '0;
         if (!w_last) r_bit <= r_bit + BW'(1);
      end else if (r_state == SHIFT) begin
         r_div <= r_div + DW'(1);
      end
   end

   assign bus.load_ready = (r_state == IDLE);
   assign bus.busy       = (r_state == SHIFT);
   assign bus.sr_out     = r_sh[0];
   assign bus.sr_en      = w_strobe;
   assign bus.done       = w_last;

endmodule

// File: tb/tb_n_shift_tx.sv
// Directed bench for n_shift_tx at DIV=1 and DIV=3, checked every cycle
// against a bit-period timing model plus hand-computed expectations.
module tb_n_shift_tx;

   typedef struct packed {
      logic ready;
      logic busy;
      logic sr_out;
      logic sr_en;
      logic done;
   } out_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   n_shift_tx_if #(.N(7)) a_if ();
   n_shift_tx_if #(.N(7)) b_if ();

   n_shift_tx #(.N(7), .DIV(1)) u_a (.clk(clk), .rst(rst), .bus(a_if));
   n_shift_tx #(.N(7), .DIV(3)) u_b (.clk(clk), .rst(rst), .bus(b_if));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Model state: cycle index k within the word (1..7*DIV) while active.
   bit         m_act[2] = '{1'b0, 1'b0};
   int         m_k[2]   = '{0, 0};
   logic [6:0] m_w[2];
   int         m_div[2] = '{1, 3};

   function automatic out_t model_out(input bit act, input int k, input logic [6:0] w, input int div);
      out_t o;
      if (!act) begin
         o = '{ready: 1'b1, busy: 1'b0, sr_out: 1'b0, sr_en: 1'b0, done: 1'b0};
      end else begin
         o.ready  = 1'b0;
         o.busy   = 1'b1;
         o.sr_out = w[(k - 1) / div];
         o.sr_en  = ((k % div) == 0);
         o.done   = (k == 7 * div);
      end
      return o;
   endfunction

   int         edge_n = 0;
   bit         prev_ready[2] = '{1'b0, 1'b0};
   int         acc_edge[2]  = '{0, 0};
   int         acc_cnt[2]   = '{0, 0};
   int         done_cyc[2]  = '{0, 0};
   int         done_cnt[2]  = '{0, 0};
   int         rdy_cyc[2]   = '{0, 0};
   logic [6:0] pr[2]        = '{7'h0, 7'h0};
   logic [6:0] rxw[2]       = '{7'h0, 7'h0};
   logic [6:0] rxq_a[$];
   logic       bits_a[$];
   int         en_b[$];

   always @(posedge clk) begin
      logic       in_lv[2];
      logic [6:0] in_din[2];
      logic       r;
      out_t       dut[2];
      out_t       exp;
      edge_n++;
      r         = rst;
      in_lv[0]  = a_if.load_valid;
      in_din[0] = a_if.din;
      in_lv[1]  = b_if.load_valid;
      in_din[1] = b_if.din;
      for (int i = 0; i < 2; i++) begin
         if (r && in_lv[i] && prev_ready[i]) begin
            acc_edge[i] = edge_n;
            acc_cnt[i]++;
         end
         if (!r) m_act[i] = 1'b0;
         else if (!m_act[i]) begin
            if (in_lv[i]) begin
               m_act[i] = 1'b1;
               m_k[i]   = 1;
               m_w[i]   = in_din[i];
            end
         end else if (m_k[i] == 7 * m_div[i]) m_act[i] = 1'b0;
         else m_k[i]++;
      end
      #1;
      dut[0] = {a_if.load_ready, a_if.busy, a_if.sr_out, a_if.sr_en, a_if.done};
      dut[1] = {b_if.load_ready, b_if.busy, b_if.sr_out, b_if.sr_en, b_if.done};
      for (int i = 0; i < 2; i++) begin
         exp = model_out(m_act[i], m_k[i], m_w[i], m_div[i]);
         check($sformatf("cyc%0d_dut%0d_outputs", edge_n + 1, i), dut[i], exp);
         if (dut[i].sr_en) begin
            pr[i] = {dut[i].sr_out, pr[i][6:1]};
            if (i == 0) bits_a.push_back(dut[i].sr_out);
            else        en_b.push_back(edge_n + 1);
         end
         if (dut[i].done) begin
            done_cyc[i] = edge_n + 1;
            done_cnt[i]++;
            rxw[i] = pr[i];
            if (i == 0) rxq_a.push_back(pr[i]);
         end
         if (dut[i].ready && !prev_ready[i]) rdy_cyc[i] = edge_n + 1;
         prev_ready[i] = dut[i].ready;
      end
   end

   task automatic wait_done(input int i, input int target, input string nm);
      for (int t = 0; t < 60 && done_cnt[i] < target; t++) @(negedge clk);
      check(nm, done_cnt[i] >= target, 1);
   endtask

   task automatic wait_acc(input int target, input string nm);
      for (int t = 0; t < 60 && acc_cnt[0] < target; t++) @(negedge clk);
      check(nm, acc_cnt[0] >= target, 1);
   endtask

   initial begin
      logic exp_bits[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      int   base, acc0, e1;

      // Reset held with a word offered: nothing may be accepted.
      rst = 1'b0;
      a_if.load_valid = 1'b1; a_if.din = 7'h55;
      b_if.load_valid = 1'b0; b_if.din = 7'h00;
      repeat (3) @(negedge clk);
      check("rst_no_word", acc_cnt[0] + done_cnt[0], 0);
      check("rst_busy", a_if.busy, 0);
      rst = 1'b1;
      a_if.load_valid = 1'b0;
      @(negedge clk);
      check("rel_ready", a_if.load_ready, 1);
      check("rel_busy", a_if.busy, 0);

      // Single word 7'h4B at DIV=1.
      base = done_cnt[0];
      bits_a.delete();
      a_if.load_valid = 1'b1; a_if.din = 7'h4B;
      @(negedge clk);
      a_if.load_valid = 1'b0; a_if.din = 7'h3C;
      wait_done(0, base + 1, "w4b_timeout");
      repeat (2) @(negedge clk);
      check("w4b_nbits", bits_a.size(), 7);
      for (int j = 0; j < bits_a.size() && j < 7; j++)
         check($sformatf("w4b_bit%0d", j), bits_a[j], exp_bits[j]);
      check("w4b_rx", rxw[0], 7'h4B);
      check("w4b_done_lat", done_cyc[0] - acc_edge[0], 7);
      check("w4b_ready_lat", rdy_cyc[0] - acc_edge[0], 8);

      // Paced word 7'h01 at DIV=3.
      en_b.delete();
      b_if.load_valid = 1'b1; b_if.din = 7'h01;
      @(negedge clk);
      b_if.load_valid = 1'b0; b_if.din = 7'h7E;
      wait_done(1, 1, "div3_timeout");
      repeat (2) @(negedge clk);
      check("div3_nstrobes", en_b.size(), 7);
      for (int j = 0; j < en_b.size(); j++)
         check($sformatf("div3_strobe%0d", j), en_b[j] - acc_edge[1], 3 * (j + 1));
      check("div3_done_lat", done_cyc[1] - acc_edge[1], 21);
      check("div3_rx", rxw[1], 7'h01);
      check("div3_ready_lat", rdy_cyc[1] - acc_edge[1], 22);

      // Back-to-back 7'h7F then 7'h00 with load_valid held high.
      base = done_cnt[0];
      acc0 = acc_cnt[0];
      a_if.load_valid = 1'b1; a_if.din = 7'h7F;
      wait_acc(acc0 + 1, "b2b_acc1_timeout");
      e1 = acc_edge[0];
      a_if.din = 7'h00;
      wait_acc(acc0 + 2, "b2b_acc2_timeout");
      a_if.load_valid = 1'b0; a_if.din = 7'h55;
      check("b2b_gap", acc_edge[0] - e1, 8);
      wait_done(0, base + 2, "b2b_timeout");
      check("b2b_rx1", rxq_a[rxq_a.size() - 2], 7'h7F);
      check("b2b_rx2", rxq_a[rxq_a.size() - 1], 7'h00);

      // Reset during the 4th bit of 7'h2A, then 7'h15.
      @(negedge clk);
      base = done_cnt[0];
      acc0 = acc_cnt[0];
      a_if.load_valid = 1'b1; a_if.din = 7'h2A;
      wait_acc(acc0 + 1, "mid_acc_timeout");
      a_if.load_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check("mid_ready", a_if.load_ready, 1);
      check("mid_busy", a_if.busy, 0);
      check("mid_sr_en", a_if.sr_en, 0);
      check("mid_sr_out", a_if.sr_out, 0);
      repeat (5) @(negedge clk);
      check("mid_no_done", done_cnt[0], base);
      a_if.load_valid = 1'b1; a_if.din = 7'h15;
      @(negedge clk);
      a_if.load_valid = 1'b0;
      wait_done(0, base + 1, "mid_next_timeout");
      check("mid_next_rx", rxq_a[rxq_a.size() - 1], 7'h15);

      // load_valid pulse with 7'h33 during the shift of 7'h6C.
      @(negedge clk);
      base = done_cnt[0];
      acc0 = acc_cnt[0];
      a_if.load_valid = 1'b1; a_if.din = 7'h6C;
      wait_acc(acc0 + 1, "ign_acc_timeout");
      a_if.load_valid = 1'b0;
      @(negedge clk);
      a_if.load_valid = 1'b1; a_if.din = 7'h33;
      @(negedge clk);
      check("ign_ready", a_if.load_ready, 0);
      a_if.load_valid = 1'b0;
      wait_done(0, base + 1, "ign_timeout");
      repeat (3) @(negedge clk);
      check("ign_rx", rxq_a[rxq_a.size() - 1], 7'h6C);
      check("ign_acc_count", acc_cnt[0] - acc0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/n_shift_tx.md
# n_shift_tx

Parallel-in, serial-out transmitter that feeds the team's N-bit right-shift receive register. It accepts an N-bit word through a valid/ready handshake and drives it out LSB first on `sr_out`. A one-cycle `sr_en` strobe marks each bit, so a right-shift receiver clocked on the same `clk`, with `SR_in = sr_out` and `enable = sr_en`, holds exactly `din` after N strobes. It sits on the transmit side of the serial link and can optionally pace bits with a programmable cycle divider.

## Interface
- `N`, default 7: word width in bits; N ≥ 2.
- `DIV`, default 1: clock cycles per bit period; DIV ≥ 1.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, synchronous, active-low.
- `load_valid`  in  1: `din` holds a word to send.
- `load_ready`  out  1: transmitter can accept a word (IDLE).
- `din`  in  N: parallel word; sampled only on handshake.
- `sr_out`  out  1: serial data, LSB first.
- `sr_en`  out  1: one-cycle strobe; receiver shifts on this cycle's rising edge.
- `busy`  out  1: word in flight.
- `done`  out  1: one-cycle pulse on the final bit's strobe.

## Operation
- State machine with two states, IDLE and SHIFT.
- Internal registers:
  - shift register `sh[N-1:0]`;
  - bit counter, 0..N-1, width clog2(N);
  - divider counter, 0..DIV-1, width max(1, clog2(DIV)).
- Reset (`rst=0` at a clock edge):
  - state goes to IDLE; `sh`, bit counter and divider are cleared;
  - `sr_out=0`, `sr_en=0`, `busy=0`, `done=0`, `load_ready=1` in the next cycle;
  - applies mid-word too: the word is discarded, nothing resumes.
- IDLE:
  - `load_ready=1`, `busy=0`, `sr_out=0`, `sr_en=0`;
  - on `load_valid & load_ready`: `sh<=din`, bit counter and divider are cleared, move to SHIFT.
- SHIFT:
  - `load_ready=0`, `busy=1`;
  - `sr_out=sh[0]`, driven from a register, glitch-free and stable for the whole bit period;
  - divider increments every cycle; `sr_en=1` when divider == DIV-1, otherwise 0.
- On each `sr_en` cycle:
  - divider goes to 0;
  - `sh <= {1'b0, sh[N-1:1]}`;
  - bit counter increments.
- Last bit: when `sr_en=1` and bit counter == N-1:
  - `done=1` in that same cycle;
  - next state is IDLE; the bit counter does not wrap past N-1.
- `load_valid` during SHIFT is ignored; `din` may change freely after acceptance.
- `din` is don't-care whenever `load_valid=0`.
- No parity or framing bits: exactly N bits per word.

## Timing
- Handshake accepted at rising edge E (`load_valid=1`, `load_ready=1` in the cycle before E).
- Bit i (i = 0..N-1) occupies cycles E+1+i·DIV through E+(i+1)·DIV.
- `sr_en` is high only in the last cycle of each bit period, cycle E+(i+1)·DIV.
- `done` and the final `sr_en` coincide in cycle E+N·DIV.
- `load_ready=1` again in cycle E+N·DIV+1.
- Word throughput: one word per N·DIV+1 cycles, with continuous `load_valid`.
- DIV=1: `sr_en` is high on every SHIFT cycle, one bit per clock.
- All outputs are registered or decoded from state and counters only; no combinational path from inputs to outputs except none (`load_ready` depends only on state).
- Reset is only sampled on rising `clk`; no asynchronous behaviour.

## Test plan
- **Reset values:** hold `rst=0` for 3 cycles with `load_valid=1` and `din=7'h55`, then release. Required: all outputs at reset values throughout; `load_ready=1` in the first cycle after release; no word sent while reset is held.
- **Single word, N=7, DIV=1:** load `7'h4B`. Required:
  - `sr_out` sequence 1,1,0,1,0,0,1 on seven consecutive `sr_en` cycles;
  - `done` with the 7th strobe;
  - a right-shift receiver reads PR=`7'h4B`;
  - `load_ready` returns 8 cycles after the handshake.
- **Paced, N=7, DIV=3:** load `7'h01`. Required:
  - `sr_en` every 3rd cycle (cycles E+3, E+6, …, E+21);
  - `sr_out=1` during cycles E+1..E+3, then 0;
  - `done` at E+21; receiver PR=`7'h01`.
- **Back-to-back:** `load_valid` held high with `din` = `7'h7F`, then `7'h00`. Required:
  - second handshake exactly at cycle E+N·DIV+1;
  - receiver reads `7'h7F`, then `7'h00`;
  - `din` changes made during SHIFT do not alter the bits on the wire.
- **Reset mid-word:** assert `rst=0` during the 4th bit of `7'h2A`. Required: next cycle IDLE with `sr_out=0`, `sr_en=0`, `busy=0`, no `done`; a following load of `7'h15` transmits correctly.
- **Ignored load:** pulse `load_valid` with `din=7'h33` during SHIFT. Required: no state change, `load_ready` stays 0, and the in-flight word completes unchanged.
